// File: rtl/vga_timing.sv
// VGA raster timing generator: free-running pixel/line counters with registered
// sync/blank flags, a start-of-frame tick and a completed-frame counter.
module vga_timing #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [10:0] o_hcount,
    output logic [10:0] o_vcount,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_hblnk,
    output logic        o_vblnk,
    output logic [11:0] o_rgb,
    output logic        o_frame_tick,
    output logic [15:0] o_frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_BLNK_START = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_BLNK_START = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_hblnk;
    logic        r_vblnk;
    logic        r_frame_tick;
    logic [15:0] r_frame_cnt;

    logic        w_h_wrap;
    logic        w_frame_wrap;
    logic [10:0] w_hcount_nxt;
    logic [10:0] w_vcount_nxt;

    always_comb begin
        w_h_wrap     = (r_hcount == H_LAST);
        w_frame_wrap = w_h_wrap && (r_vcount == V_LAST);
        w_hcount_nxt = r_hcount + 11'd1;
        w_vcount_nxt = r_vcount;
        if (w_h_wrap) begin
            w_hcount_nxt = 11'd0;
            w_vcount_nxt = (r_vcount == V_LAST) ? 11'd0 : r_vcount + 11'd1;
        end
    end

    // Flags are decoded from the next counter values so they land in the same
    // register stage as the counters they describe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hcount     <= 11'd0;
            r_vcount     <= 11'd0;
            r_hsync      <= 1'b0;
            r_vsync      <= 1'b0;
            r_hblnk      <= 1'b0;
            r_vblnk      <= 1'b0;
            r_frame_tick <= 1'b0;
            r_frame_cnt  <= 16'd0;
        end else begin
            r_hcount     <= w_hcount_nxt;
            r_vcount     <= w_vcount_nxt;
            r_hsync      <= (w_hcount_nxt >= H_SYNC_START) && (w_hcount_nxt < H_SYNC_END);
            r_hblnk      <= (w_hcount_nxt >= H_BLNK_START);
            r_vsync      <= (w_vcount_nxt >= V_SYNC_START) && (w_vcount_nxt < V_SYNC_END);
            r_vblnk      <= (w_vcount_nxt >= V_BLNK_START);
            r_frame_tick <= w_frame_wrap;
            if (w_frame_wrap) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign o_hcount     = r_hcount;
    assign o_vcount     = r_vcount;
    assign o_hsync      = r_hsync;
    assign o_vsync      = r_vsync;
    assign o_hblnk      = r_hblnk;
    assign o_vblnk      = r_vblnk;
    assign o_rgb        = 12'h000;
    assign o_frame_tick = r_frame_tick;
    assign o_frame_cnt  = r_frame_cnt;
endmodule
